alu_seq_ctrl: RTL
=================

# alu_seq_ctrl

- Sequencing controller for the 32-bit ALU with sequential multiplier.
- Accepts one operation per `start` handshake.
- Single-cycle logic and arithmetic ops complete in one cycle; MUL is driven as an iterative shift-add over `WIDTH` cycles.
- Drives the `mul_seq_dp` iteration datapath and returns a registered result with a one-cycle `done` pulse.
- Sits between the top-level ALU wrapper and the bitwise/adder/multiplier datapath.

## Interface
- `WIDTH`, 32: operand width. Product is `2*WIDTH`.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `start` input 1: request. Accepted only in IDLE or DONE.
- `op` input 3: opcode. 000 AND, 001 OR, 010 XOR, 011 ADD, 100 SUB, 101 SLT, 110 NOR, 111 MUL.
- `a` input WIDTH: operand A. MUL multiplicand.
- `b` input WIDTH: operand B. MUL multiplier.
- `busy` output 1: high while in EXEC or MUL_RUN.
- `done` output 1: one-cycle pulse; result valid.
- `result` output WIDTH: low word of the result.
- `result_hi` output WIDTH: high product word for MUL; 0 for all other ops.

## Operation
- States and transitions:
  - IDLE: on `start`, go to EXEC for non-MUL ops, or MUL_RUN for MUL.
  - EXEC: go to DONE.
  - MUL_RUN: loop until the iteration count reaches `WIDTH` (or the early-exit condition), then go to DONE.
  - DONE: go back to IDLE; if `start` is high, behave exactly as IDLE+`start`.
- On accept, register `op`, `a` and `b`. Input changes after acceptance have no effect.
- Single-cycle ops:
  - AND, OR, XOR and NOR are bitwise.
  - ADD and SUB wrap modulo 2^WIDTH; carry and overflow are discarded.
  - SLT: `result` = 1 if signed `a` < signed `b`, else 0.
- MUL iteration (unsigned), using `acc[2W]`, `mcand[2W]` and `mplier[W]`:
  - On accept, load `acc`=0, `mcand`={0,a}, `mplier`=b, `cnt`=0.
  - Each MUL_RUN cycle: if `mplier[0]` is set, `acc` += `mcand`. Then `mcand` <<= 1, `mplier` >>= 1, `cnt`++.
  - On DONE: {`result_hi`,`result`} = `acc`.
- `result` and `result_hi` update only on entry to DONE. They hold until the next DONE.
- `start` while `busy` is ignored: no queueing, no error.
- `rst_n` low at any time (including mid-MUL) aborts the operation. All state and outputs clear immediately.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `result`=0, `result_hi`=0, `cnt`=0.
- Start accepted at edge N:
  - Non-MUL: `busy`=1 during N+1 (EXEC), `done`=1 during N+2.
  - MUL without early exit: MUL_RUN occupies N+1..N+WIDTH, `done`=1 during N+WIDTH+1 (N+33 at default width).
- Back-to-back: a `start` during DONE is accepted. That cycle's `done` pulse still completes, and `busy` rises the next cycle.
- `done` and `busy` are never high together.

## Configuration
- Macro `ALU_SEQ_MUL_EARLY_EXIT_EN`.
- When defined, MUL_RUN exits to DONE after the iteration that leaves `mplier`==0. Iterations k = index of the highest set bit of `b` + 1, so `done` is at N+k+1.
- When defined and `b`==0, the accept goes IDLE→DONE directly: `done` at N+1 with product 0.
- When undefined, MUL always runs exactly `WIDTH` iterations.
- All other ops are identical in both builds.

## Structure
- Package `alu_pkg` holds:
  - Opcode localparams (`OP_AND`..`OP_MUL`).
  - State enum (IDLE, EXEC, MUL_RUN, DONE).
  - `ALU_W`=32 and counter width `$clog2(ALU_W)+1`.
- Sub-module `mul_seq_dp`:
  - Holds the `acc`/`mcand`/`mplier` registers.
  - Controlled by `load` and `step` from the FSM.
  - Exports `mplier_zero` and `product`.
- Single-cycle ops and the FSM live in `alu_seq_ctrl`.

## Test plan
- Reset mid-operation: MUL `a`=5, `b`=7, `rst_n` pulsed low at N+10.
  - Required: `busy`, `done` and `result` go to 0 immediately; no `done` pulse follows.
  - Afterwards, XOR of 0x00000000 and 0xFFFFFFFF → `result`=0xFFFFFFFF with `done` at N+2.
- Single-cycle ops:
  - XOR 0x54001000 ^ 0xE0001FFF → 0xB4000FFF.
  - ADD 0xFFFFFFFF+1 → 0, `result_hi`=0.
  - SUB 0-1 → 0xFFFFFFFF.
  - SLT 0x80000000 vs 1 → 1.
  - `done` at N+2 for each.
- MUL full width: 0xFFFFFFFF × 0xFFFFFFFF → `result_hi`=0xFFFFFFFE, `result`=0x00000001.
  - `done` at N+33 without the macro.
- Early exit (macro defined):
  - `b`=0 → `done` at N+1, product 0.
  - `b`=1, `a`=0x12345678 → `done` at N+2, `result`=0x12345678.
  - `b`=0x80000000 → `done` at N+33.
- Handshake: `start` (ADD 2+3) asserted during MUL_RUN is ignored.
  - Then assert `start` (AND 0xF0F0F0F0 & 0xFF00FF00) during the MUL's DONE cycle.
  - Required: accepted, with `result`=0xF000F000 two cycles later.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcodes, FSM states, widths.
package alu_pkg;

    localparam int ALU_W     = 32;
    localparam int ALU_CNT_W = $clog2(ALU_W) + 1;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_XOR = 3'b010;
    localparam logic [2:0] OP_ADD = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b100;
    localparam logic [2:0] OP_SLT = 3'b101;
    localparam logic [2:0] OP_NOR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXEC    = 2'd1,
        MUL_RUN = 2'd2,
        DONE    = 2'd3
    } state_t;

endpackage

// File: rtl/mul_seq_dp.sv
// Shift-add multiplier iteration datapath (unsigned, one multiplier bit per step).
// o_product / o_mplier_zero describe the state *after* the current step, so the
// controller can capture the final product on the same edge as the last step.
module mul_seq_dp
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_W
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_load,
    input  logic               i_step,
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    output logic               o_mplier_zero,
    output logic [2*WIDTH-1:0] o_product
);

    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [2*WIDTH-1:0] w_acc_nxt;

    assign w_acc_nxt     = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign o_product     = w_acc_nxt;
    assign o_mplier_zero = ((r_mplier >> 1) == '0);

    // load operands on accept, otherwise advance one iteration per step
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
        end else if (i_load) begin
            r_acc    <= '0;
            r_mcand  <= {{WIDTH{1'b0}}, i_a};
            r_mplier <= i_b;
        end else if (i_step) begin
            r_acc    <= w_acc_nxt;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
        end
    end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Sequencing controller: single-cycle logic/arith ops plus iterative MUL.
// Optional build macro ALU_SEQ_MUL_EARLY_EXIT_EN: MUL stops once the remaining
// multiplier bits are all zero (b==0 goes straight to DONE).
module alu_seq_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_W
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [2:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_result,
    output logic [WIDTH-1:0] o_result_hi
);

`ifdef ALU_SEQ_MUL_EARLY_EXIT_EN
    localparam bit EARLY_EXIT = 1'b1;
`else
    localparam bit EARLY_EXIT = 1'b0;
`endif

    localparam int               CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    state_t             r_state;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_result;
    logic [WIDTH-1:0]   r_result_hi;
    logic [CNT_W-1:0]   r_cnt;
    logic [2:0]         r_op;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;

    logic               w_accept;
    logic               w_load;
    logic               w_step;
    logic               w_mplier_zero;
    logic [2*WIDTH-1:0] w_product;
    logic [WIDTH-1:0]   w_alu_res;

    assign w_accept = i_start && ((r_state == IDLE) || (r_state == DONE));
    assign w_load   = w_accept && (i_op == OP_MUL);
    assign w_step   = (r_state == MUL_RUN);

    mul_seq_dp #(.WIDTH(WIDTH)) u_mul_dp (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_load        (w_load),
        .i_step        (w_step),
        .i_a           (i_a),
        .i_b           (i_b),
        .o_mplier_zero (w_mplier_zero),
        .o_product     (w_product)
    );

    // single-cycle result from the latched operands
    always_comb begin
        w_alu_res = '0;
        case (r_op)
            OP_AND:  w_alu_res = r_a & r_b;
            OP_OR:   w_alu_res = r_a | r_b;
            OP_XOR:  w_alu_res = r_a ^ r_b;
            OP_ADD:  w_alu_res = r_a + r_b;
            OP_SUB:  w_alu_res = r_a - r_b;
            OP_SLT:  w_alu_res = {{(WIDTH-1){1'b0}}, ($signed(r_a) < $signed(r_b))};
            OP_NOR:  w_alu_res = ~(r_a | r_b);
            default: w_alu_res = '0;
        endcase
    end

    // control FSM with registered busy/done/result
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_result    <= '0;
            r_result_hi <= '0;
            r_cnt       <= '0;
            r_op        <= OP_AND;
            r_a         <= '0;
            r_b         <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE, DONE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    if (i_start) begin
                        r_op  <= i_op;
                        r_a   <= i_a;
                        r_b   <= i_b;
                        r_cnt <= '0;
                        if (i_op != OP_MUL) begin
                            r_state <= EXEC;
                            r_busy  <= 1'b1;
                        end else if (EARLY_EXIT && (i_b == '0)) begin
                            r_state     <= DONE;
                            r_done      <= 1'b1;
                            r_result    <= '0;
                            r_result_hi <= '0;
                        end else begin
                            r_state <= MUL_RUN;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                EXEC: begin
                    r_state     <= DONE;
                    r_busy      <= 1'b0;
                    r_done      <= 1'b1;
                    r_result    <= w_alu_res;
                    r_result_hi <= '0;
                end
                MUL_RUN: begin
                    r_cnt <= r_cnt + 1'b1;
                    if ((r_cnt == LAST) || (EARLY_EXIT && w_mplier_zero)) begin
                        r_state     <= DONE;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                        r_result    <= w_product[WIDTH-1:0];
                        r_result_hi <= w_product[2*WIDTH-1:WIDTH];
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_result    = r_result;
    assign o_result_hi = r_result_hi;

endmodule
